// File: rtl/uart_wb_host_if.sv
// uart_wb_host_if: command/response channels, Wishbone
// master bus and interrupt lines of the UART host bridge.
interface uart_wb_host_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_we;
   logic [2:0] req_addr;
   logic [7:0] req_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic [2:0] wb_addr_o;
   logic [3:0] wb_sel_o;
   logic [7:0] wb_dat_o;
   logic [7:0] wb_dat_i;
   logic       wb_we_o;
   logic       wb_stb_o;
   logic       wb_cyc_o;
   logic       wb_ack_i;
   logic       int_i;
   logic       irq_pending;
   logic       irq_rise;

   modport master (
      input  req_valid, req_we, req_addr, req_data,
      input  rsp_ready, wb_dat_i, wb_ack_i, int_i,
      output req_ready, rsp_valid, rsp_data, rsp_err,
      output wb_addr_o, wb_sel_o, wb_dat_o,
      output wb_we_o, wb_stb_o, wb_cyc_o,
      output irq_pending, irq_rise
   );

   modport slave (
      output req_valid, req_we, req_addr, req_data,
      output rsp_ready, wb_dat_i, wb_ack_i, int_i,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
      input  wb_addr_o, wb_sel_o, wb_dat_o,
      input  wb_we_o, wb_stb_o, wb_cyc_o,
      input  irq_pending, irq_rise
   );
endinterface

// File: rtl/uart_wb_host.sv
// uart_wb_host: runs one classic Wishbone cycle per command
// with a timeout, and synchronises the UART interrupt.
module uart_wb_host #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic           clk,
   input logic           wb_rst_n,
   uart_wb_host_if.master bus
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      CYCLE,
      RESP
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            req_ready_q, req_ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [7:0]      rsp_data_q, rsp_data_d;
   logic            rsp_err_q, rsp_err_d;
   logic [2:0]      wb_addr_q, wb_addr_d;
   logic [3:0]      wb_sel_q, wb_sel_d;
   logic [7:0]      wb_dat_q, wb_dat_d;
   logic            wb_we_q, wb_we_d;
   logic            wb_cyc_q, wb_cyc_d;
   logic            sync1_q, sync1_d;
   logic            pend_q, pend_d;
   logic            rise_q, rise_d;

   // Next-state and next-output logic for the bus FSM
   // and the interrupt synchroniser.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      wb_addr_d   = wb_addr_q;
      wb_sel_d    = wb_sel_q;
      wb_dat_d    = wb_dat_q;
      wb_we_d     = wb_we_q;
      wb_cyc_d    = wb_cyc_q;

      unique case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (bus.req_valid && req_ready_q) begin
               state_d     = CYCLE;
               cnt_d       = '0;
               req_ready_d = 1'b0;
               wb_cyc_d    = 1'b1;
               wb_we_d     = bus.req_we;
               wb_addr_d   = bus.req_addr;
               wb_sel_d    = 4'b0001 << bus.req_addr[1:0];
               wb_dat_d    = bus.req_we ? bus.req_data
                                        : 8'h00;
            end
         end
         CYCLE: begin
            // ack wins over a coincident timeout
            if (bus.wb_ack_i) begin
               state_d     = RESP;
               wb_cyc_d    = 1'b0;
               wb_we_d     = 1'b0;
               rsp_data_d  = wb_we_q ? 8'h00 : bus.wb_dat_i;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
            end else if (cnt_q == CNT_MAX) begin
               state_d     = RESP;
               wb_cyc_d    = 1'b0;
               wb_we_d     = 1'b0;
               rsp_data_d  = 8'h00;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      sync1_d = bus.int_i;
      pend_d  = sync1_q;
      rise_d  = sync1_q & ~pend_q;
   end

   // State and registered outputs; reset clears everything.
   always_ff @(posedge clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         rsp_err_q   <= 1'b0;
         wb_addr_q   <= 3'd0;
         wb_sel_q    <= 4'd0;
         wb_dat_q    <= 8'h00;
         wb_we_q     <= 1'b0;
         wb_cyc_q    <= 1'b0;
         sync1_q     <= 1'b0;
         pend_q      <= 1'b0;
         rise_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         wb_addr_q   <= wb_addr_d;
         wb_sel_q    <= wb_sel_d;
         wb_dat_q    <= wb_dat_d;
         wb_we_q     <= wb_we_d;
         wb_cyc_q    <= wb_cyc_d;
         sync1_q     <= sync1_d;
         pend_q      <= pend_d;
         rise_q      <= rise_d;
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.wb_addr_o   = wb_addr_q;
   assign bus.wb_sel_o    = wb_sel_q;
   assign bus.wb_dat_o    = wb_dat_q;
   assign bus.wb_we_o     = wb_we_q;
   assign bus.wb_stb_o    = wb_cyc_q;
   assign bus.wb_cyc_o    = wb_cyc_q;
   assign bus.irq_pending = pend_q;
   assign bus.irq_rise    = rise_q;
endmodule

// File: tb/tb_uart_wb_host.sv
// tb_uart_wb_host: directed and randomized transactions
// checked against a transaction-level reference model.
module tb_uart_wb_host;
   localparam int T = 8;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   uart_wb_host_if bus ();

   uart_wb_host #(
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk      (clk),
      .wb_rst_n (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
      end
   endtask

   task automatic chk_idle_rst();
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_cyc", bus.wb_cyc_o, 0);
      chk("rst_stb", bus.wb_stb_o, 0);
      chk("rst_we", bus.wb_we_o, 0);
      chk("rst_addr", bus.wb_addr_o, 0);
      chk("rst_sel", bus.wb_sel_o, 0);
      chk("rst_dat", bus.wb_dat_o, 0);
      chk("rst_irq_p", bus.irq_pending, 0);
      chk("rst_irq_r", bus.irq_rise, 0);
   endtask

   // One command: slave acks in bus cycle wait_n+1
   // (never if wait_n >= T), then bp cycles of backpressure.
   task automatic txn(input logic       we,
                      input logic [2:0] addr,
                      input logic [7:0] data,
                      input int         wait_n,
                      input logic [7:0] rdata,
                      input int         bp,
                      input bit         stray);
      int         n;
      int         exp_cyc;
      logic       exp_err;
      logic [7:0] exp_rd;
      logic [3:0] exp_sel;
      logic [7:0] exp_do;
      logic [7:0] held_d;
      logic       held_e;
      exp_err = (wait_n >= T);
      exp_cyc = exp_err ? T : wait_n + 1;
      exp_rd  = (!we && !exp_err) ? rdata : 8'h00;
      exp_sel = 4'(1 << (addr % 4));
      exp_do  = we ? data : 8'h00;

      @(negedge clk);
      chk("req_ready_idle", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_data  = data;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom);
      bus.req_addr  = 3'($urandom);
      bus.req_data  = 8'($urandom);
      n = 0;
      while (bus.wb_cyc_o === 1'b1 && n < T + 4) begin
         n++;
         chk("bus_addr", bus.wb_addr_o, addr);
         chk("bus_sel", bus.wb_sel_o, exp_sel);
         chk("bus_dat", bus.wb_dat_o, exp_do);
         chk("bus_we", bus.wb_we_o, we);
         chk("bus_stb", bus.wb_stb_o, 1);
         chk("busy_ready", bus.req_ready, 0);
         chk("busy_rsp", bus.rsp_valid, 0);
         bus.wb_ack_i = (n == wait_n + 1);
         bus.wb_dat_i = (n == wait_n + 1) ? rdata
                                          : 8'($urandom);
         @(negedge clk);
      end
      bus.wb_ack_i = 1'b0;
      chk("cyc_cycles", n, exp_cyc);
      chk("end_stb", bus.wb_stb_o, 0);
      chk("end_we", bus.wb_we_o, 0);
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_data", bus.rsp_data, exp_rd);
      chk("rsp_err", bus.rsp_err, exp_err);
      chk("rsp_ready_lo", bus.req_ready, 0);
      held_d = bus.rsp_data;
      held_e = bus.rsp_err;
      for (int i = 0; i < bp; i++) begin
         bus.wb_ack_i = stray && (i == bp / 2);
         bus.wb_dat_i = 8'($urandom);
         @(negedge clk);
         bus.wb_ack_i = 1'b0;
         chk("bp_valid", bus.rsp_valid, 1);
         chk("bp_data", bus.rsp_data, exp_rd);
         chk("bp_err", bus.rsp_err, exp_err);
         chk("bp_ready", bus.req_ready, 0);
         chk("bp_cyc", bus.wb_cyc_o, 0);
      end
      chk("bp_hold_d", bus.rsp_data, held_d);
      chk("bp_hold_e", bus.rsp_err, held_e);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("post_valid", bus.rsp_valid, 0);
      chk("post_ready", bus.req_ready, 1);
      chk("post_cyc", bus.wb_cyc_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int rises;
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 3'd0;
      bus.req_data  = 8'h00;
      bus.rsp_ready = 1'b0;
      bus.wb_dat_i  = 8'h00;
      bus.wb_ack_i  = 1'b0;
      bus.int_i     = 1'b0;
      #1;
      chk_idle_rst();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_ready", bus.req_ready, 1);

      txn(1'b1, 3'd3, 8'h83, 0, 8'h00, 0, 1'b0);
      txn(1'b0, 3'd5, 8'h00, 3, 8'h60, 0, 1'b0);
      txn(1'b0, 3'd1, 8'h00, T + 1, 8'h5a, 0, 1'b0);
      txn(1'b0, 3'd2, 8'h00, T - 1, 8'ha5, 0, 1'b0);
      txn(1'b1, 3'd6, 8'h3c, 1, 8'h00, 10, 1'b1);

      // reset in the middle of a bus cycle
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 3'd7;
      bus.req_data  = 8'hee;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("mid_cyc", bus.wb_cyc_o, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle_rst();
      @(negedge clk);
      chk_idle_rst();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready", bus.req_ready, 1);
      bus.wb_ack_i = 1'b1;
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rel_no_rsp", bus.rsp_valid, 0);
         chk("rel_no_cyc", bus.wb_cyc_o, 0);
      end

      // interrupt synchroniser
      bus.int_i = 1'b1;
      @(negedge clk);
      chk("irq_p_e1", bus.irq_pending, 0);
      chk("irq_r_e1", bus.irq_rise, 0);
      @(negedge clk);
      chk("irq_p_e2", bus.irq_pending, 1);
      chk("irq_r_e2", bus.irq_rise, 1);
      rises = 1;
      repeat (3) begin
         @(negedge clk);
         chk("irq_p_hold", bus.irq_pending, 1);
         if (bus.irq_rise === 1'b1) rises++;
      end
      chk("irq_rises", rises, 1);
      bus.int_i = 1'b0;
      @(negedge clk);
      chk("irq_f_e1", bus.irq_pending, 1);
      chk("irq_f_r1", bus.irq_rise, 0);
      @(negedge clk);
      chk("irq_f_e2", bus.irq_pending, 0);
      chk("irq_f_r2", bus.irq_rise, 0);

      for (int k = 0; k < 40; k++) begin
         txn(1'($urandom),
             3'($urandom),
             8'($urandom),
             int'($urandom_range(0, T + 2)),
             8'($urandom),
             int'($urandom_range(0, 3)),
             1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_wb_host.md
# uart_wb_host

Wishbone single-cycle master that sits directly upstream of the UART core's Wishbone slave port. It accepts byte-wide register read/write requests on a valid/ready command channel and executes each as one classic Wishbone cycle on the UART bus. It returns read data or a timeout error on a valid/ready response channel. It also synchronises the UART interrupt line for the host-side logic.

## Interface
- TIMEOUT_CYCLES, 255, number of cycles cyc/stb stay asserted without ack before the cycle is abandoned; legal range 1..65535
- clk  in  1  single clock; all logic on posedge
- wb_rst_n  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk upstream
- req_valid  in  1  command present
- req_ready  out  1  block can accept a command
- req_we  in  1  1 = register write, 0 = register read
- req_addr  in  3  UART register address
- req_data  in  8  write data; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  8  read data; 0 for writes and timeouts
- rsp_err  out  1  1 = cycle timed out
- wb_addr_o  out  3  to UART wb_addr_i
- wb_sel_o  out  4  to UART wb_sel_i
- wb_dat_o  out  8  to UART wb_dat_i
- wb_dat_i  in  8  from UART wb_dat_o
- wb_we_o, wb_stb_o, wb_cyc_o  out  1 each  to UART wb_we_i / wb_stb_i / wb_cyc_i
- wb_ack_i  in  1  from UART wb_ack_o
- int_i  in  1  from UART int_o; asynchronous
- irq_pending  out  1  synchronised int_i level
- irq_rise  out  1  one-cycle pulse on each synchronised 0->1 edge of int_i

## Operation
- FSM states: IDLE, CYCLE, RESP. All outputs are registered.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture we/addr/data, clear the timeout counter, and go to CYCLE.
  - On the same edge, drive wb_cyc_o=wb_stb_o=1, wb_we_o=req_we, wb_addr_o=req_addr, wb_dat_o=req_data (0 for reads), and wb_sel_o=4'b0001<<req_addr[1:0].
- CYCLE:
  - req_ready=0.
  - Bus outputs are held stable until the cycle ends.
  - wb_ack_i=1: drop cyc/stb/we on that edge and load rsp_data (wb_dat_i if read, 0 if write). Set rsp_err=0 and rsp_valid=1, then go to RESP.
  - No ack and counter==TIMEOUT_CYCLES-1: drop cyc/stb/we, set rsp_data=0, rsp_err=1, rsp_valid=1, then go to RESP. Otherwise the counter increments.
  - Ack and timeout on the same cycle: ack wins (rsp_err=0).
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are held stable.
  - On rsp_ready, clear rsp_valid, set req_ready=1, and go to IDLE.
- wb_ack_i outside CYCLE is ignored and produces no response.
- The timeout counter width is $clog2(TIMEOUT_CYCLES+1). It never wraps, because it is cleared on every entry to CYCLE.
- Interrupt path: a two-flop synchroniser on int_i drives irq_pending. irq_rise = sync & ~sync_q. This path is independent of the FSM.
- Reset (wb_rst_n=0), at any time including mid-cycle:
  - The FSM goes to IDLE immediately.
  - All outputs are 0, including req_ready, wb_cyc_o and wb_stb_o. Any in-flight request is dropped with no response.
  - req_ready rises on the first clk edge after deassertion.

## Timing
- Request accepted at edge E0 -> wb_cyc_o/wb_stb_o high in cycle after E0.
- Ack sampled at E0+1 (zero-wait slave) -> cyc/stb low and rsp_valid high after E0+1.
- rsp_ready high at E0+2 -> req_ready high after E0+2. The next request can be accepted at E0+3, giving a peak rate of 1 transaction per 3 cycles.
- Timeout: cyc/stb are high for exactly TIMEOUT_CYCLES cycles, then rsp_valid rises on the following cycle.
- irq_pending lags int_i by 2 edges; irq_rise is asserted in the same cycle irq_pending first goes high.

## Test plan
- Reset: hold wb_rst_n=0 mid-CYCLE with cyc high -> all outputs 0 asynchronously; after release, req_ready=1 after one edge and no rsp_valid appears.
- Write: we=1, addr=3, data=8'h83, zero-wait ack -> one cycle with wb_addr_o=3, wb_sel_o=4'b1000, wb_dat_o=8'h83, wb_we_o=1. Response is rsp_data=0, rsp_err=0, and cyc is high for exactly 1 cycle.
- Read with wait states: we=0, addr=5, ack after 4 cycles with wb_dat_i=8'h60 -> bus outputs stable for 4 cycles, then rsp_data=8'h60, rsp_err=0.
- Timeout: TIMEOUT_CYCLES=8, no ack -> cyc high for 8 cycles, then rsp_err=1, rsp_data=0. Also: ack on the 8th cycle -> rsp_err=0.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid, rsp_data and rsp_err held; req_ready=0 and no new bus cycle starts; a stray wb_ack_i pulse has no effect.
- Interrupt: int_i 0->1 held for 5 cycles -> irq_pending high 2 edges later, irq_rise high exactly 1 cycle; int_i fall -> irq_pending low 2 edges later, no pulse.
